seq_mult: RTL
=============

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 The block SHALL take parameter W, default 8, giving the operand width; legal when W >= 4 and W is even.
REQ-002 The block SHALL take parameter R, default 2, giving the multiplier bits retired per cycle; legal when R divides W and 1 <= R <= W.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  operand pair x/y/sgn present.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 x  in  W  multiplicand.
REQ-008 y  in  W  multiplier.
REQ-009 sgn  in  1  1 = x, y two's complement; 0 = unsigned.
REQ-010 out_valid  out  1  product p valid.
REQ-011 out_ready  in  1  consumer accepts p.
REQ-012 p  out  2W  full-precision product.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 IDLE: in_ready=1, out_valid=0.
REQ-015 An input SHALL be accepted on a rising edge with in_valid && in_ready.
REQ-016 On acceptance, the block SHALL register |x|, |y| (magnitudes if sgn=1, raw if sgn=0) and neg = sgn & (x[W-1] ^ y[W-1]).
REQ-017 On acceptance, the block SHALL clear the accumulator and the step counter, then move to BUSY.
REQ-018 Magnitude of -2^(W-1) SHALL be 2^(W-1), held as an unsigned W-bit value.
REQ-019 BUSY: in_ready=0, out_valid=0.
REQ-020 BUSY step k (k = 0..W/R-1) SHALL compute acc += (|x| * |y|[kR+R-1:kR]) << kR, exact to 2W bits.
REQ-021 The BUSY step count SHALL be exactly W/R.
REQ-022 On the last step, the block SHALL load p = neg ? -(acc_final) : acc_final (2W-bit two's complement) and move to DONE.
REQ-023 out_valid SHALL first be high W/R cycles after the acceptance edge.
REQ-024 DONE: out_valid=1, in_ready=0, p held stable.
REQ-025 On out_valid && out_ready, the FSM SHALL return to IDLE; p retains its value, out_valid=0.
REQ-026 DONE with out_ready=0 SHALL hold indefinitely; p SHALL NOT change.
REQ-027 x, y, sgn and in_valid changes during BUSY/DONE SHALL be ignored and SHALL NOT affect the result.
REQ-028 in_valid high while in_ready=0 SHALL cause no acceptance and no error.
REQ-029 There SHALL be no overlap: a new operand is accepted no earlier than the cycle after the DONE handshake.
REQ-030 Results SHALL be exact for all operand pairs in both modes; no overflow is possible (2W bits cover (-2^(W-1))^2 = 2^(2W-2)).
REQ-031 The step counter width SHALL be clog2(W/R), minimum 1, and it SHALL never wrap inside an operation.

Reset
REQ-032 rst_n low SHALL immediately force: state=IDLE, in_ready=1 after release, out_valid=0, p=0, acc=0, counter=0, neg=0.
REQ-033 Reset asserted mid-BUSY or mid-DONE SHALL abandon the operation; no out_valid for it ever appears.
REQ-034 The first acceptance after reset release SHALL behave as a fresh operation.

Structure
REQ-035 A shared package seq_mult_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the default W, R constants.
REQ-036 Sub-module seq_mult_step SHALL be purely combinational: inputs acc[2W], mag_x[W], y_chunk[R], k; output next acc.
REQ-037 Within seq_mult_step, the partial-product rows SHALL be compressed with HA/FA cells, then summed by a prefix adder.
REQ-038 The seq_mult top SHALL hold the FSM, the operand/accumulator registers and the sign fix-up.

Verification (W=8, R=2 unless stated)
REQ-039 Unsigned: sgn=0, x=0xFF, y=0xFF -> out_valid exactly 4 cycles after acceptance, p=0xFE01.
REQ-040 Signed corner: sgn=1, x=0x80, y=0x80 -> p=0x4000; sgn=1, x=0xFD (-3), y=0x05 -> p=0xFFF1.
REQ-041 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, p stable; in_ready=0.
REQ-041 (cont.) x/y toggling during this window -> no effect on p.
REQ-042 Reset mid-BUSY (step 2): rst_n low 1 cycle -> out_valid=0, p=0, in_ready=1 after release.
REQ-042 (cont.) A next op of 0x07*0x09 -> 0x003F.
REQ-043 Parameter sweep: W=4/R=1 (latency 4), W=16/R=4 (latency 4), W=16/R=16 (latency 1).
REQ-043 (cont.) Exhaustive for W=4, random for W=16, both sgn modes, against a reference model.
REQ-044 Back-to-back: in_valid held high, out_ready=1 -> one acceptance per W/R+2 cycles, results in order.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding,
// default operand width / radix, and the step-counter width helper.
package seq_mult_pkg;

  localparam int unsigned W_DEFAULT = 8;
  localparam int unsigned R_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter width: clog2(steps), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One radix-2^R accumulation step (purely combinational):
//   acc_o = acc_i + ((mag_x_i * y_chunk_i) << (k_i * R)), modulo 2^(2W).
// Ports:
//   acc_i     [2W] running accumulator
//   mag_x_i   [W]  unsigned multiplicand magnitude
//   y_chunk_i [R]  multiplier digit retired this step
//   k_i       [KW] step index
//   acc_o     [2W] updated accumulator
module seq_mult_step
  import seq_mult_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned R  = R_DEFAULT,
  parameter int unsigned KW = cnt_width(W / R)
) (
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   mag_x_i,
  input  logic [R-1:0]   y_chunk_i,
  input  logic [KW-1:0]  k_i,
  output logic [2*W-1:0] acc_o
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] x_base;
  logic [PW-1:0] sum_v;
  logic [PW-1:0] carry_v;

  // Kogge-Stone carry-propagate adder; g ends as the group carry of bits [i:0].
  function automatic logic [PW-1:0] ks_add(input logic [PW-1:0] a,
                                           input logic [PW-1:0] b);
    logic [PW-1:0] h;
    logic [PW-1:0] g;
    logic [PW-1:0] pr;
    logic [PW-1:0] g_n;
    logic [PW-1:0] p_n;
    h  = a ^ b;
    g  = a & b;
    pr = h;
    for (int d = 1; d < int'(PW); d = d * 2) begin
      g_n = g;
      p_n = pr;
      for (int i = d; i < int'(PW); i++) begin
        g_n[i] = g[i] | (pr[i] & g[i-d]);
        p_n[i] = pr[i] & pr[i-d];
      end
      g  = g_n;
      pr = p_n;
    end
    return h ^ {g[PW-2:0], 1'b0};
  endfunction

  // Carry-save reduction: accumulator + R shifted partial-product rows
  // collapse to one sum/carry pair (HA row first, then a FA row per digit bit).
  always_comb begin
    logic [PW-1:0] row;
    logic [PW-1:0] t;
    x_base  = PW'(mag_x_i) << (32'(k_i) * R);
    row     = y_chunk_i[0] ? x_base : '0;
    sum_v   = acc_i ^ row;
    carry_v = (acc_i & row) << 1;
    for (int j = 1; j < int'(R); j++) begin
      row     = y_chunk_i[j] ? (x_base << j) : '0;
      t       = sum_v ^ carry_v ^ row;
      carry_v = ((sum_v & carry_v) | (sum_v & row) | (carry_v & row)) << 1;
      sum_v   = t;
    end
  end

  assign acc_o = ks_add(sum_v, carry_v);

endmodule

// File: rtl/seq_mult.sv
// Sequential signed/unsigned multiplier retiring R multiplier bits per cycle.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake (x, y, sgn)
//   x, y [W]              multiplicand / multiplier
//   sgn                   1 = two's complement operands, 0 = unsigned
//   out_valid/out_ready   product handshake
//   p [2W]                full-precision product, held until next result
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT,
  parameter int unsigned R = R_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int unsigned STEPS = W / R;
  localparam int unsigned CW    = cnt_width(STEPS);
  localparam int unsigned PW    = 2 * W;

  state_e        state_q, state_d;
  logic [W-1:0]  mag_x_q, mag_x_d;
  logic [W-1:0]  mag_y_q, mag_y_d;
  logic          neg_q, neg_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] p_q, p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [R-1:0]  y_chunk;
  logic [PW-1:0] acc_next;

  // Unsigned magnitude; -2^(W-1) maps onto itself as an unsigned value.
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v,
                                             input logic       s);
    return (s && v[W-1]) ? W'(~v + W'(1)) : v;
  endfunction

  assign y_chunk = R'(mag_y_q >> (32'(cnt_q) * R));

  seq_mult_step #(
    .W  (W),
    .R  (R),
    .KW (CW)
  ) u_step (
    .acc_i     (acc_q),
    .mag_x_i   (mag_x_q),
    .y_chunk_i (y_chunk),
    .k_i       (cnt_q),
    .acc_o     (acc_next)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_x_q     <= '0;
      mag_y_q     <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_x_q     <= mag_x_d;
      mag_y_q     <= mag_y_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, datapath update and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    mag_x_d = mag_x_q;
    mag_y_d = mag_y_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_x_d = magnitude(x, sgn);
          mag_y_d = magnitude(y, sgn);
          neg_d   = sgn & (x[W-1] ^ y[W-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_next;
        if (cnt_q == CW'(STEPS - 1)) begin
          // Last step: counter stays put so it never wraps.
          p_d     = neg_q ? PW'(~acc_next + PW'(1)) : acc_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule
